// File: rtl/imm_gen_pipe_if.sv
// Stream interface for imm_gen_pipe: instruction in, immediate + format tag out.
// The imm_illegal signal exists only when IMMGEN_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_data;
    logic [2:0]      imm_fmt;
`ifdef IMMGEN_ILLEGAL_EN
    logic            imm_illegal;

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, imm_data, imm_fmt, imm_illegal
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, imm_data, imm_fmt, imm_illegal
    );
`else
    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, imm_data, imm_fmt
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, imm_data, imm_fmt
    );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with a 2-entry skid buffer.
// Decodes I/S/B/U/J/shift-amount immediates by full opcode, extends to XLEN and
// delivers {imm, fmt} over a valid/ready stream. in_ready is registered so there
// is no combinational path from out_ready back to the producer.
// Optional feature macro: IMMGEN_ILLEGAL_EN (adds imm_illegal, set for NONE entries).
module imm_gen_pipe #(
    parameter int unsigned XLEN = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    imm_gen_pipe_if.slave      io
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            in_ready_q;

    logic [XLEN-1:0] head_imm, skid_imm;
    logic [2:0]      head_fmt, skid_fmt;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic [63:0]     imm64;

    logic            accept, pop;
    logic            load_head_in, load_head_skid, load_skid;

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [2:0]      funct3;

    assign ins    = io.instruction;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];

    // Decode the presented instruction into a 64-bit immediate and a format tag;
    // the result is truncated to XLEN so XLEN=32 needs no zero-width replication.
    always_comb begin
        imm64   = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FMT_SH;
                    if (XLEN == 64) imm64 = {58'd0, ins[25:20]};
                    else            imm64 = {59'd0, ins[24:20]};
                end else begin
                    dec_fmt = FMT_I;
                    imm64   = {{52{ins[31]}}, ins[31:20]};
                end
            end
            7'b0011011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FMT_SH;
                    imm64   = {59'd0, ins[24:20]};
                end else begin
                    dec_fmt = FMT_I;
                    imm64   = {{52{ins[31]}}, ins[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                imm64   = {{52{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm64   = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm64   = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm64   = {{32{ins[31]}}, ins[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm64   = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: begin
                dec_fmt = FMT_NONE;
                imm64   = '0;
            end
        endcase
        dec_imm = imm64[XLEN-1:0];
    end

    assign accept = io.in_valid & in_ready_q;
    assign pop    = io.out_valid & io.out_ready;

    // Next-state and buffer-load control; flush overrides any accept or pop.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register; in_ready is precomputed from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    // Head/skid payload registers; contents hold when not loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_imm <= '0;
            head_fmt <= '0;
            skid_imm <= '0;
            skid_fmt <= '0;
        end else begin
            if (load_head_in) begin
                head_imm <= dec_imm;
                head_fmt <= dec_fmt;
            end else if (load_head_skid) begin
                head_imm <= skid_imm;
                head_fmt <= skid_fmt;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
            end
        end
    end

`ifdef IMMGEN_ILLEGAL_EN
    logic head_ill, skid_ill;

    // Illegal flag travels alongside its entry through the same head/skid path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ill <= 1'b0;
            skid_ill <= 1'b0;
        end else begin
            if (load_head_in)        head_ill <= (dec_fmt == FMT_NONE);
            else if (load_head_skid) head_ill <= skid_ill;
            if (load_skid)           skid_ill <= (dec_fmt == FMT_NONE);
        end
    end

    assign io.imm_illegal = head_ill;
`endif

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = (state != EMPTY);
    assign io.imm_data  = head_imm;
    assign io.imm_fmt   = head_fmt;

endmodule
